// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: splits a LANES x DW vector load or store into
// one scalar access per enabled lane on a single data-memory port.
// Only one access is in flight at a time. The upstream pipeline is stalled
// until the last enabled lane has finished.
module vector_mem_sequencer #(
    parameter int unsigned LANES    = 16,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 21,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         stride,
    input  logic [LANES-1:0]      lane_mask,
    input  logic [LANES*DW-1:0]   wdata_vec,
    input  logic [DW-1:0]         mem_rdata,
    output logic [LANES*DW-1:0]   rdata_vec,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  stall,
    output logic                  done
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  store_q, store_d;
    logic [AW-1:0]         base_q, base_d;
    logic [AW-1:0]         stride_q, stride_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [LANES*DW-1:0]   wdata_q, wdata_d;
    logic [LANES*DW-1:0]   rdata_q, rdata_d;

    logic                  first_any;
    logic [LW-1:0]         first_idx;
    logic                  next_any;
    logic [LW-1:0]         next_idx;
    logic [AW-1:0]         lane_addr;
    logic [DW-1:0]         lane_wdata;

    // Lowest enabled lane of the incoming request mask.
    always_comb begin
        first_any = 1'b0;
        first_idx = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_mask[i] && !first_any) begin
                first_any = 1'b1;
                first_idx = LW'(i);
            end
        end
    end

    // Lowest enabled lane strictly above the current pointer.
    always_comb begin
        next_any = 1'b0;
        next_idx = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask_q[i] && (i > 32'(ptr_q)) && !next_any) begin
                next_any = 1'b1;
                next_idx = LW'(i);
            end
        end
    end

    // Address and store data of the lane under the pointer; the address
    // arithmetic is truncated to AW bits so it wraps silently.
    always_comb begin
        lane_addr  = base_q + (AW'(ptr_q) * stride_q);
        lane_wdata = wdata_q[32'(ptr_q)*DW +: DW];
    end

    // Next-state logic and memory-port outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        store_d   = store_q;
        base_d    = base_q;
        stride_d  = stride_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = (state_q != S_IDLE);
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall = start;
                if (start) begin
                    store_d  = is_store;
                    base_d   = base_addr;
                    stride_d = stride;
                    mask_d   = lane_mask;
                    wdata_d  = wdata_vec;
                    ptr_d    = first_idx;
                    state_d  = first_any ? S_ISSUE : S_DONE;
                end
            end

            S_ISSUE: begin
                stall    = 1'b1;
                mem_addr = lane_addr;
                if (store_q) begin
                    mem_wdata = lane_wdata;
                    mem_we    = 1'b1;
                    if (next_any) begin
                        ptr_d = next_idx;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                stall    = 1'b1;
                mem_addr = lane_addr;
                if (cnt_q == CW'(READ_LAT - 1)) begin
                    rdata_d[32'(ptr_q)*DW +: DW] = mem_rdata;
                    if (next_any) begin
                        ptr_d   = next_idx;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                done    = 1'b1;
                ptr_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata_vec = rdata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: directed table plus randomized
// operations, checked cycle by cycle against a timing/data reference model.
module tb_vector_mem_sequencer;

    localparam int unsigned LANES = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 21;
    localparam int unsigned RL    = 1;
    localparam int          MAXC  = 64;
    localparam int          TW    = AW + 1 + DW + 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                is_store;
    logic [AW-1:0]       base_addr;
    logic [AW-1:0]       stride;
    logic [LANES-1:0]    lane_mask;
    logic [LANES*DW-1:0] wdata_vec;
    logic [DW-1:0]       mem_rdata;
    logic [LANES*DW-1:0] rdata_vec;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_we;
    logic                busy;
    logic                stall;
    logic                done;

    int errors = 0;
    int checks = 0;

    vector_mem_sequencer #(
        .LANES(LANES),
        .DW(DW),
        .AW(AW),
        .READ_LAT(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_store(is_store),
        .base_addr(base_addr),
        .stride(stride),
        .lane_mask(lane_mask),
        .wdata_vec(wdata_vec),
        .mem_rdata(mem_rdata),
        .rdata_vec(rdata_vec),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .busy(busy),
        .stall(stall),
        .done(done)
    );

    always #5 clk = ~clk;

    // Read-only memory: contents equal the address unless overridden.
    logic [DW-1:0] mem_ovr [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return DW'(a);
    endfunction

    // One-cycle read latency memory.
    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    // Expected rdata_vec contents.
    logic [DW-1:0] rd_model [LANES];

    function automatic logic [LANES*DW-1:0] pack_model();
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = rd_model[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [LANES*DW-1:0] act,
                         input logic [LANES*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation starting in cycle 0; every cycle up to one past
    // done is compared with timing derived from the enabled lane count.
    task automatic run_op(input string tag, input bit st, input logic [AW-1:0] b,
                          input logic [AW-1:0] s, input logic [LANES-1:0] m,
                          input logic [LANES*DW-1:0] wd, input bit poke,
                          output int act_done);
        logic [AW-1:0] e_addr [MAXC+1];
        logic          e_we   [MAXC+1];
        logic [DW-1:0] e_wd   [MAXC+1];
        logic [AW-1:0] a;
        logic [TW-1:0] got, want;
        int n, c, terr, exp_done;
        for (int i = 0; i <= MAXC; i++) begin
            e_addr[i] = '0; e_we[i] = 1'b0; e_wd[i] = '0;
        end
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                a = AW'(64'(b) + 64'(i) * 64'(s));
                if (st) begin
                    c = 1 + n;
                    e_addr[c] = a; e_we[c] = 1'b1; e_wd[c] = wd[i*DW +: DW];
                end else begin
                    for (int k = 0; k <= RL; k++) e_addr[1 + n*(1+RL) + k] = a;
                    rd_model[i] = mem_fn(a);
                end
                n++;
            end
        end
        exp_done = st ? n + 1 : n * (1 + RL) + 1;

        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = b; stride = s;
        lane_mask = m; wdata_vec = wd;
        #1;
        check({tag, "/start_cycle"}, {mem_addr, mem_we, busy, stall, done},
              {{AW{1'b0}}, 4'b0010});

        terr = 0;
        act_done = 0;
        for (c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            if (poke && c <= exp_done) begin
                start = 1'b1;
                is_store = 1'($urandom);
                base_addr = AW'($urandom);
                stride = AW'($urandom);
                lane_mask = LANES'($urandom);
                for (int i = 0; i < LANES; i++) wdata_vec[i*DW +: DW] = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done && act_done == 0) act_done = c;
            got  = {mem_addr, mem_we, mem_wdata, busy, stall, done};
            if (c <= exp_done)
                want = {e_addr[c], e_we[c], e_wd[c], 1'b1, (c < exp_done), (c == exp_done)};
            else
                want = '0;
            if (got !== want) begin
                if (terr == 0)
                    $display("detail %s cycle %0d: got %0h want %0h", tag, c, got, want);
                terr++;
            end
        end
        check({tag, "/trace"}, LANES*DW'(terr), '0);
        check({tag, "/rdata"}, rdata_vec, pack_model());
    endtask

    typedef struct {
        string            tag;
        bit               st;
        logic [AW-1:0]    b;
        logic [AW-1:0]    s;
        logic [LANES-1:0] m;
        bit               poke;
        int               done_c;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*DW-1:0] wd;
        logic [AW-1:0] b, s;
        logic [LANES-1:0] m;
        int dc;
        bit st;

        tbl[0] = '{"st_full",    1'b1, 21'h00100,  21'd1, 16'hFFFF, 1'b0, 17};
        tbl[1] = '{"ld_full",    1'b0, 21'h00200,  21'd4, 16'hFFFF, 1'b0, 33};
        tbl[2] = '{"ld_preload", 1'b0, 21'h00300,  21'd1, 16'hFFFF, 1'b0, 33};
        tbl[3] = '{"ld_sparse",  1'b0, 21'h00200,  21'd4, 16'h8001, 1'b0, 5};
        tbl[4] = '{"st_wrap",    1'b1, 21'h1FFFFE, 21'd1, 16'h000F, 1'b0, 5};
        tbl[5] = '{"st_mask0",   1'b1, 21'h00123,  21'd7, 16'h0000, 1'b1, 1};
        tbl[6] = '{"st_stride0", 1'b1, 21'h00050,  21'd0, 16'h0F0F, 1'b1, 9};
        tbl[7] = '{"ld_mask0",   1'b0, 21'h00400,  21'd3, 16'h0000, 1'b0, 1};

        for (int i = 0; i < LANES; i++) begin
            rd_model[i] = '0;
            mem_ovr[AW'(32'h300 + i)] = 32'hDEAD_BEEF;
        end

        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0;
        lane_mask = '0; wdata_vec = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {rdata_vec, mem_addr, mem_wdata, mem_we, busy, stall, done}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 32'hA000_0000 + i;
            run_op(tbl[t].tag, tbl[t].st, tbl[t].b, tbl[t].s, tbl[t].m, wd, tbl[t].poke, dc);
            check({tbl[t].tag, "/done_cycle"}, LANES*DW'(dc), LANES*DW'(tbl[t].done_c));
        end

        // Sparse load merged into the 0xDEADBEEF preload.
        check("sparse_lane0",  rdata_vec[0*DW +: DW],  32'h0000_0200);
        check("sparse_lane1",  rdata_vec[1*DW +: DW],  32'hDEAD_BEEF);
        check("sparse_lane15", rdata_vec[15*DW +: DW], 32'h0000_023C);

        // Randomized operations.
        for (int r = 0; r < 24; r++) begin
            st = 1'($urandom);
            b  = AW'($urandom);
            case ($urandom % 3)
                0: s = '0;
                1: s = AW'($urandom_range(1, 7));
                default: s = AW'($urandom);
            endcase
            case ($urandom % 5)
                0: m = '0;
                1: m = LANES'(1) << $urandom_range(0, LANES-1);
                default: m = LANES'($urandom);
            endcase
            for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = $urandom;
            run_op($sformatf("rand%0d", r), st, b, s, m, wd, (r % 3) == 0, dc);
        end

        // Reset in cycle 5 of a 16-lane store.
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; base_addr = 21'h00400; stride = 21'd2;
        lane_mask = 16'hFFFF;
        for (int i = 0; i < LANES; i++) wdata_vec[i*DW +: DW] = $urandom;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        check("abort/pre_reset_write", {mem_we, mem_addr, busy, stall},
              {1'b1, 21'h00408, 2'b11});
        rst = 1'b1;
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            if (c == 6) rst = 1'b0;
            #1;
            check($sformatf("abort/cycle%0d", c),
                  {rdata_vec, mem_addr, mem_wdata, mem_we, busy, stall, done}, '0);
        end
        for (int i = 0; i < LANES; i++) rd_model[i] = '0;

        for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = $urandom;
        run_op("post_reset_ld", 1'b0, 21'h00500, 21'd3, 16'h5A5A, wd, 1'b0, dc);
        check("post_reset_ld/done_cycle", LANES*DW'(dc), LANES*DW'(17));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
